// File: rtl/nn_mac_pipe.sv
// rtl/nn_mac_pipe.sv - multi-lane signed multiply-accumulate execute unit
// Two-stage pipe: stage 1 multiplies, stage 2 updates accumulators and loads saturated READ results.
module nn_mac_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_op,
  input  logic [LANES*DATA_WIDTH-1:0]   in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_sat,
  output logic                          busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } opT;

  logic                        s1Valid;
  opT                          s1Op;
  logic signed [PW-1:0]        s1Prod  [LANES];
  logic signed [ACC_WIDTH-1:0] acc     [LANES];
  logic signed [PW-1:0]        mulA    [LANES];
  logic signed [PW-1:0]        mulB    [LANES];
  logic signed [PW-1:0]        mulP    [LANES];
  logic signed [ACC_WIDTH-1:0] prodExt [LANES];
  logic [LANES*DATA_WIDTH-1:0] satData;
  logic [LANES-1:0]            satFlag;
  logic                        adv;
  logic                        inFire;
  logic                        s2Fire;

  // A stalled output register freezes both stages; s1 may still fill if empty.
  assign adv      = !out_valid || out_ready;
  assign in_ready = !RST && (!s1Valid || adv);
  assign inFire   = in_valid && in_ready;
  assign s2Fire   = s1Valid && adv;
  assign busy     = s1Valid || out_valid;

  always_comb begin
    satData = '0;
    satFlag = '0;
    for (int i = 0; i < LANES; i++) begin
      mulA[i]    = PW'($signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]));
      mulB[i]    = PW'($signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
      mulP[i]    = mulA[i] * mulB[i];
      prodExt[i] = ACC_WIDTH'(s1Prod[i]);
      if (acc[i] > SAT_MAX) begin
        satData[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
        satFlag[i] = 1'b1;
      end else if (acc[i] < SAT_MIN) begin
        satData[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
        satFlag[i] = 1'b1;
      end else begin
        satData[i*DATA_WIDTH +: DATA_WIDTH] = acc[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1Valid <= 1'b0;
      s1Op    <= OP_MUL;
      for (int i = 0; i < LANES; i++) s1Prod[i] <= '0;
    end else if (inFire) begin
      s1Valid <= 1'b1;
      s1Op    <= opT'(in_op);
      for (int i = 0; i < LANES; i++) s1Prod[i] <= mulP[i];
    end else if (adv) begin
      s1Valid <= 1'b0;
    end
  end

  // Accumulators live only in stage 2, so a READ behind a MAC always sees its result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      if (s2Fire) begin
        for (int i = 0; i < LANES; i++) begin
          case (s1Op)
            OP_MUL:  acc[i] <= prodExt[i];
            OP_MAC:  acc[i] <= acc[i] + prodExt[i];
            OP_CLR:  acc[i] <= '0;
            default: acc[i] <= acc[i];
          endcase
        end
      end
      if (s2Fire && s1Op == OP_READ) begin
        out_valid <= 1'b1;
        out_data  <= satData;
        out_sat   <= satFlag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nn_mac_pipe.sv
// tb/tb_nn_mac_pipe.sv - directed vectors, stall/reset sequences and random run against a golden model
module tb_nn_mac_pipe;

  localparam logic [1:0] MUL = 2'b00, MAC = 2'b01, CLR = 2'b10, READ = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  out_sat;
  logic        busy;

  nn_mac_pipe #(.DATA_WIDTH(16), .LANES(4), .ACC_WIDTH(40)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // 0: hold low, 1: hold high, 2: random each cycle
  int readyMode = 1;
  always @(posedge CLK) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [67:0] rxQ[$];
  always @(negedge CLK)
    if (!RST && out_valid && out_ready) rxQ.push_back({out_data, out_sat});

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expD;
    logic [3:0]  expS;
  } vecT;

  vecT         vecs[$];
  logic [67:0] expQ[$];
  int          rxPtr = 0;
  int          nChecks = 0;
  int          nPass = 0;
  longint      mAcc[4];

  function automatic logic [63:0] pk(int l0, int l1, int l2, int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  function automatic longint wrap40(longint x);
    longint y;
    y = x <<< 24;
    return y >>> 24;
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic syncP();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      output int accCyc);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    accCyc = -1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        accCyc = cyc;
        break;
      end
      syncP();
    end
    if (accCyc < 0) chk("send_timeout", 68'd0, 68'd1);
    syncP();
    in_valid = 1'b0;
  endtask

  task automatic expectBeats();
    while (rxPtr < expQ.size()) begin
      int t = 0;
      while (rxQ.size() <= rxPtr && t < 2000) begin
        @(negedge CLK);
        t++;
      end
      if (rxQ.size() <= rxPtr) begin
        chk("beat_timeout", 68'(rxQ.size()), 68'(expQ.size()));
        rxPtr = expQ.size();
      end else begin
        chk("beat_data", 68'(rxQ[rxPtr][67:4]), 68'(expQ[rxPtr][67:4]));
        chk("beat_sat",  68'(rxQ[rxPtr][3:0]),  68'(expQ[rxPtr][3:0]));
        rxPtr++;
      end
    end
    syncP();
  endtask

  task automatic waitOutValid(input string name);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk(name, 68'(out_valid), 68'd1);
    syncP();
  endtask

  task automatic modelOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic [3:0]  s;
    d = '0; s = '0;
    for (int i = 0; i < 4; i++) begin
      longint p;
      longint v;
      p = longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      case (op)
        MUL: mAcc[i] = p;
        MAC: mAcc[i] = wrap40(mAcc[i] + p);
        CLR: mAcc[i] = 0;
        default: ;
      endcase
      v = mAcc[i];
      if (v > 32767)       begin d[i*16 +: 16] = 16'h7fff; s[i] = 1'b1; end
      else if (v < -32768) begin d[i*16 +: 16] = 16'h8000; s[i] = 1'b1; end
      else                 d[i*16 +: 16] = v[15:0];
    end
    if (op == READ) expQ.push_back({d, s});
  endtask

  function automatic logic [63:0] rndLanes();
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[i*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
    return r;
  endfunction

  initial begin
    int c0;
    int c1;
    int nAcc;
    int rxBefore;
    RST = 1'b1; in_valid = 1'b0; in_op = MUL; in_a = '0; in_b = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready",  68'(in_ready),  68'd0);
    chk("rst_out_valid", 68'(out_valid), 68'd0);
    chk("rst_busy",      68'(busy),      68'd0);
    chk("rst_out_data",  68'(out_data),  68'd0);
    chk("rst_out_sat",   68'(out_sat),   68'd0);
    RST = 1'b0;
    #1;
    chk("in_ready_after_rst", 68'(in_ready), 68'd1);
    syncP();

    // READ latency: out_valid two cycles after acceptance
    send(MUL, pk(3, -2, 0, 7), pk(4, 5, 9, -1), c0);
    send(READ, '0, '0, c0);
    expQ.push_back({pk(12, -10, 0, -7), 4'b0000});
    c1 = -1;
    for (int t = 0; t < 20 && c1 < 0; t++) begin
      @(negedge CLK);
      if (out_valid) c1 = cyc;
    end
    chk("read_latency", 68'(c1 - c0), 68'd2);
    syncP();
    expectBeats();

    // Directed vector table, back-to-back
    vecs.push_back('{MUL,  pk(3, -2, 0, 7), pk(4, 5, 9, -1), '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(12, -10, 0, -7), 4'b0000});
    vecs.push_back('{MUL,  pk(5, 5, 5, 5), pk(5, 5, 5, 5), '0, 4'b0});
    vecs.push_back('{MAC,  pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(26, 26, 26, 26), 4'b0000});
    vecs.push_back('{CLR,  '0, '0, '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(0, 0, 0, 0), 4'b0000});
    vecs.push_back('{MUL,  pk(-32768, -32768, 32767, 0), pk(-32768, 32767, 32767, 0), '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(32767, -32768, 32767, 0), 4'b0111});
    vecs.push_back('{MUL,  pk(181, -181, 1, -1), pk(181, 181, 32767, -32768), '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(32761, -32761, 32767, 32767), 4'b1000});
    vecs.push_back('{MUL,  pk(-128, -129, -1, 1), pk(256, 256, 1, -1), '0, 4'b0});
    vecs.push_back('{READ, '0, '0, pk(-32768, -32768, -1, -1), 4'b0010});
    vecs.push_back('{READ, '0, '0, pk(-32768, -32768, -1, -1), 4'b0010});
    foreach (vecs[k]) begin
      send(vecs[k].op, vecs[k].a, vecs[k].b, c0);
      if (vecs[k].op == READ) expQ.push_back({vecs[k].expD, vecs[k].expS});
    end
    expectBeats();

    // 100 MACs of +/-200*200 saturate
    send(CLR, '0, '0, c0);
    repeat (100) send(MAC, pk(200, 200, 200, 200), pk(200, 200, 200, 200), c0);
    send(READ, '0, '0, c0);
    expQ.push_back({pk(32767, 32767, 32767, 32767), 4'b1111});
    send(CLR, '0, '0, c0);
    repeat (100) send(MAC, pk(-200, -200, -200, -200), pk(200, 200, 200, 200), c0);
    send(READ, '0, '0, c0);
    expQ.push_back({pk(-32768, -32768, -32768, -32768), 4'b1111});
    expectBeats();

    // Backpressure: pipe freezes, exactly one beat slips into s1
    readyMode = 0;
    syncP(); syncP();
    send(CLR, '0, '0, c0);
    send(MUL, pk(7, 7, 7, 7), pk(1, 1, 1, 1), c0);
    send(READ, '0, '0, c0);
    expQ.push_back({pk(7, 7, 7, 7), 4'b0000});
    waitOutValid("stall_out_valid");
    rxBefore = rxQ.size();
    in_valid = 1'b1; in_op = MAC; in_a = pk(1, 1, 1, 1); in_b = pk(1, 1, 1, 1);
    nAcc = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      if (in_ready) nAcc++;
      syncP();
    end
    in_valid = 1'b0;
    chk("stall_accepts",  68'(nAcc),     68'd1);
    chk("stall_in_ready", 68'(in_ready), 68'd0);
    chk("stall_data",     68'(out_data), 68'(pk(7, 7, 7, 7)));
    chk("stall_busy",     68'(busy),     68'd1);
    chk("stall_no_xfer",  68'(rxQ.size()), 68'(rxBefore));
    readyMode = 1;
    send(READ, '0, '0, c0);
    expQ.push_back({pk(8, 8, 8, 8), 4'b0000});
    expectBeats();

    // Asynchronous reset with s1 and output register both full
    readyMode = 0;
    syncP(); syncP();
    send(MUL, pk(3, 3, 3, 3), pk(3, 3, 3, 3), c0);
    send(READ, '0, '0, c0);
    waitOutValid("pre_rst_out_valid");
    send(MAC, pk(1, 1, 1, 1), pk(1, 1, 1, 1), c0);
    chk("pre_rst_busy", 68'(busy), 68'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_out_valid", 68'(out_valid), 68'd0);
    chk("mid_rst_busy",      68'(busy),      68'd0);
    chk("mid_rst_in_ready",  68'(in_ready),  68'd0);
    chk("mid_rst_out_data",  68'(out_data),  68'd0);
    syncP();
    RST = 1'b0;
    readyMode = 1;
    syncP();
    send(READ, '0, '0, c0);
    expQ.push_back({pk(0, 0, 0, 0), 4'b0000});
    expectBeats();

    // Random ops with random out_ready against the golden model
    readyMode = 2;
    for (int i = 0; i < 4; i++) mAcc[i] = 0;
    send(CLR, '0, '0, c0);
    for (int k = 0; k < 10000; k++) begin
      int r;
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? MAC : (r < 6) ? MUL : (r < 9) ? READ : CLR;
      a  = rndLanes();
      b  = rndLanes();
      modelOp(op, a, b);
      send(op, a, b, c0);
      if ($urandom_range(0, 3) == 0) syncP();
    end
    readyMode = 1;
    expectBeats();
    repeat (5) syncP();
    chk("no_extra_beats", 68'(rxQ.size()), 68'(expQ.size()));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
